move_iterator: RTL

Sequencer downstream of `all_moves`. Once a generated move list is complete, it walks `move_index` from 0 to `move_count-1` and captures each resulting position from `all_moves`. It presents each position on a valid/ready stream to the next stage (evaluator or search stack). When the list is exhausted or the walk is aborted, it pulses `clear_moves` so `all_moves` can accept the next board.

---
 rtl/move_iterator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/move_iterator.sv
// Walks the all_moves list from index 0 to move_count-1 and streams each captured
// position on a valid/ready interface, then pulses clear_moves to release the list.
module move_iterator #(
  parameter int PIECE_WIDTH        = 4,
  parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
  parameter int MAX_POSITIONS      = 128,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
  parameter int READ_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          white_to_move_in,
  input  logic [3:0]                    castle_mask_in,
  input  logic [3:0]                    en_passant_col_in,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  input  logic                          abort,
  output logic                          pos_valid,
  input  logic                          pos_ready,
  output logic [BOARD_WIDTH-1:0]        pos_board,
  output logic                          pos_white_to_move,
  output logic [3:0]                    pos_castle_mask,
  output logic [3:0]                    pos_en_passant_col,
  output logic [MAX_POSITIONS_LOG2-1:0] pos_index,
  output logic                          pos_last,
  output logic                          done,
  output logic                          no_moves
);

  localparam int IW = MAX_POSITIONS_LOG2;
  localparam logic [2:0]    LAT_RELOAD = 3'(READ_LATENCY);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_OFFER,
    S_CLEAR,
    S_DRAIN
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          count_q;
  logic [2:0]             lat_q;
  logic [IW-1:0]          move_index_q;
  logic                   pos_valid_q;
  logic [BOARD_WIDTH-1:0] pos_board_q;
  logic                   pos_wtm_q;
  logic [3:0]             pos_castle_q;
  logic [3:0]             pos_ep_q;
  logic [IW-1:0]          pos_index_q;
  logic                   pos_last_q;
  logic                   clear_q;
  logic                   done_q;
  logic                   no_moves_q;

  logic xfer;
  logic at_last_index;

  assign xfer          = pos_valid_q & pos_ready;
  assign at_last_index = (move_index_q == (count_q - IDX_ONE));

  // Pulse outputs default low every cycle; they are raised only on entry to CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      lat_q        <= '0;
      move_index_q <= '0;
      pos_valid_q  <= 1'b0;
      pos_board_q  <= '0;
      pos_wtm_q    <= 1'b0;
      pos_castle_q <= '0;
      pos_ep_q     <= '0;
      pos_index_q  <= '0;
      pos_last_q   <= 1'b0;
      clear_q      <= 1'b0;
      done_q       <= 1'b0;
      no_moves_q   <= 1'b0;
    end else begin
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
      no_moves_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (moves_ready) begin
            count_q <= move_count;
            if (move_count == '0) begin
              clear_q    <= 1'b1;
              no_moves_q <= 1'b1;
              state_q    <= S_CLEAR;
            end else begin
              move_index_q <= '0;
              lat_q        <= LAT_RELOAD;
              state_q      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            clear_q <= 1'b1;
            state_q <= S_CLEAR;
          end else if (lat_q == 3'd0) begin
            pos_board_q  <= board_in;
            pos_wtm_q    <= white_to_move_in;
            pos_castle_q <= castle_mask_in;
            pos_ep_q     <= en_passant_col_in;
            pos_index_q  <= move_index_q;
            pos_last_q   <= at_last_index;
            pos_valid_q  <= 1'b1;
            state_q      <= S_OFFER;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_OFFER: begin
          // Abort wins over a simultaneous transfer; move_index stays frozen.
          if (abort) begin
            pos_valid_q <= 1'b0;
            clear_q     <= 1'b1;
            state_q     <= S_CLEAR;
          end else if (xfer) begin
            pos_valid_q <= 1'b0;
            if (pos_last_q) begin
              clear_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_CLEAR;
            end else begin
              move_index_q <= move_index_q + IDX_ONE;
              lat_q        <= LAT_RELOAD;
              state_q      <= S_WAIT;
            end
          end
        end
        S_CLEAR: begin
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!moves_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign move_index         = move_index_q;
  assign clear_moves        = clear_q;
  assign pos_valid          = pos_valid_q;
  assign pos_board          = pos_board_q;
  assign pos_white_to_move  = pos_wtm_q;
  assign pos_castle_mask    = pos_castle_q;
  assign pos_en_passant_col = pos_ep_q;
  assign pos_index          = pos_index_q;
  assign pos_last           = pos_last_q;
  assign done               = done_q;
  assign no_moves           = no_moves_q;

endmodule
